seg_scan: RTL and testbench

Four-digit multiplexed seven-segment display driver that sits directly downstream of the seconds counter and converts its 0–9 digit outputs into time-multiplexed segment and digit-select drive for a common-anode display. A scan counter cycles one digit at a time. A blanking gap between digits prevents ghosting. All four input digits and the decimal-point mask are snapshotted once per frame, so a multi-digit value never tears mid-frame.

---
 rtl/seg_scan.sv | 156 +++++++++++++++
 tb/tb_seg_scan.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment driver for a common-anode
// display. Digits are snapshotted once per frame and scanned 0..3, with a
// blank gap before every digit so the anodes never overlap.
module seg_scan #(
  parameter int unsigned SCAN_DIV = 24000,
  parameter int unsigned GAP_CYC  = 24
) (
  input  logic        clk,
  input  logic        res,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic        lz_blank,
  output logic [7:0]  seg,
  output logic [3:0]  sel,
  output logic        frame
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] SEL_BLANK = 4'hF;

  typedef enum logic {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      snap_digits;
  logic [3:0]       snap_dp;
  logic             snap_lz;

  logic        take_c;
  logic [15:0] eff_digits_c;
  logic [3:0]  eff_dp_c;
  logic        eff_lz_c;
  logic [3:0]  cur_v_c;
  logic        blank_c;
  logic [6:0]  glyph_c;
  logic [7:0]  drive_seg_c;
  logic [3:0]  drive_sel_c;
  logic        z3_c;
  logic        z2_c;
  logic        z1_c;

  // Snapshot strobe, and the snapshot as it will look after this edge so a
  // one-cycle gap still loads the freshly captured digit.
  always_comb begin
    take_c       = (state == GAP) && (idx == 2'd0) && (cnt == '0);
    eff_digits_c = take_c ? digits   : snap_digits;
    eff_dp_c     = take_c ? dp       : snap_dp;
    eff_lz_c     = take_c ? lz_blank : snap_lz;
  end

  // Select the current digit and work out leading-zero blanking.
  always_comb begin
    z3_c = (eff_digits_c[15:12] == 4'd0);
    z2_c = z3_c && (eff_digits_c[11:8] == 4'd0);
    z1_c = z2_c && (eff_digits_c[7:4]  == 4'd0);
    cur_v_c     = eff_digits_c[3:0];
    blank_c     = 1'b0;
    drive_sel_c = 4'b1110;
    case (idx)
      2'd0: begin
        cur_v_c     = eff_digits_c[3:0];
        blank_c     = 1'b0;
        drive_sel_c = 4'b1110;
      end
      2'd1: begin
        cur_v_c     = eff_digits_c[7:4];
        blank_c     = eff_lz_c && z1_c;
        drive_sel_c = 4'b1101;
      end
      2'd2: begin
        cur_v_c     = eff_digits_c[11:8];
        blank_c     = eff_lz_c && z2_c;
        drive_sel_c = 4'b1011;
      end
      default: begin
        cur_v_c     = eff_digits_c[15:12];
        blank_c     = eff_lz_c && z3_c;
        drive_sel_c = 4'b0111;
      end
    endcase
  end

  // Active-low {g..a} glyph; out-of-range values show a dash.
  always_comb begin
    glyph_c = 7'h3F;
    case (cur_v_c)
      4'd0:    glyph_c = 7'h40;
      4'd1:    glyph_c = 7'h79;
      4'd2:    glyph_c = 7'h24;
      4'd3:    glyph_c = 7'h30;
      4'd4:    glyph_c = 7'h19;
      4'd5:    glyph_c = 7'h12;
      4'd6:    glyph_c = 7'h02;
      4'd7:    glyph_c = 7'h78;
      4'd8:    glyph_c = 7'h00;
      4'd9:    glyph_c = 7'h10;
      default: glyph_c = 7'h3F;
    endcase
    drive_seg_c = {~eff_dp_c[idx], (blank_c ? 7'h7F : glyph_c)};
  end

  // Scan sequencer: gap/drive timing, digit index, snapshot and outputs.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= GAP;
      cnt         <= '0;
      idx         <= 2'd0;
      snap_digits <= 16'd0;
      snap_dp     <= 4'd0;
      snap_lz     <= 1'b0;
      seg         <= SEG_BLANK;
      sel         <= SEL_BLANK;
      frame       <= 1'b0;
    end else begin
      frame <= take_c;
      if (take_c) begin
        snap_digits <= digits;
        snap_dp     <= dp;
        snap_lz     <= lz_blank;
      end
      case (state)
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
            sel   <= drive_sel_c;
            seg   <= drive_seg_c;
          end else begin
            cnt <= cnt + CNT_W'(1);
            sel <= SEL_BLANK;
            seg <= SEG_BLANK;
          end
        end
        default: begin
          if (cnt == SCAN_LAST) begin
            state <= GAP;
            cnt   <= '0;
            idx   <= idx + 2'd1;
            sel   <= SEL_BLANK;
            seg   <= SEG_BLANK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=4, GAP_CYC=2 (24-cycle frame).
module tb_seg_scan;

  logic        clk;
  logic        res;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        lz_blank;
  logic [7:0]  seg;
  logic [3:0]  sel;
  logic        frame;

  int errors;
  int checks;
  int c;
  logic [3:0] prev_sel;

  seg_scan #(.SCAN_DIV(4), .GAP_CYC(2)) dut (
    .clk      (clk),
    .res      (res),
    .digits   (digits),
    .dp       (dp),
    .lz_blank (lz_blank),
    .seg      (seg),
    .sel      (sel),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One 24-cycle frame starting just before the snapshot edge. e0..e3 are the
  // hand-computed segment values per digit; digits change to chg_val at
  // frame cycle chg_at (0 = no change).
  task automatic run_frame(input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input int chg_at, input logic [15:0] chg_val);
    logic [7:0] e [4];
    int k;
    logic [3:0] xs;
    logic [7:0] xg;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      c++;
      k = (j / 6) % 4;
      if ((j % 6) >= 2) begin
        xs = ~(4'b0001 << k);
        xg = e[k];
      end else begin
        xs = 4'hF;
        xg = 8'hFF;
      end
      chk($sformatf("c%0d sel", c), {4'h0, sel}, {4'h0, xs});
      chk($sformatf("c%0d seg", c), seg, xg);
      chk($sformatf("c%0d frame", c), {7'd0, frame}, {7'd0, (j == 1)});
      if (sel == 4'hF) chk($sformatf("c%0d ghost_seg", c), seg, 8'hFF);
      chk($sformatf("c%0d onehot", c), {7'd0, ($countones(~sel) <= 1)}, 8'd1);
      if (prev_sel != 4'hF && sel != 4'hF)
        chk($sformatf("c%0d sel_step", c), {4'h0, sel}, {4'h0, prev_sel});
      prev_sel = sel;
      if (j == chg_at) digits = chg_val;
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    c        = 0;
    prev_sel = 4'hF;
    res      = 1'b0;
    digits   = 16'h1234;
    dp       = 4'b0000;
    lz_blank = 1'b0;

    // Held in reset: outputs blank.
    repeat (3) @(negedge clk);
    chk("rst seg", seg, 8'hFF);
    chk("rst sel", {4'h0, sel}, 8'h0F);
    chk("rst frame", {7'd0, frame}, 8'd0);
    res = 1'b1;

    // Cadence and decode.
    run_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 0, 16'h0);
    digits = 16'h5678;
    run_frame(8'h80, 8'hF8, 8'h82, 8'h92, 0, 16'h0);
    digits = 16'h09AF;
    run_frame(8'hBF, 8'hBF, 8'h90, 8'hC0, 0, 16'h0);

    // Leading-zero blanking.
    lz_blank = 1'b1;
    digits   = 16'h0045;
    dp       = 4'b0100;
    run_frame(8'h92, 8'h99, 8'h7F, 8'hFF, 0, 16'h0);
    digits = 16'h0000;
    dp     = 4'b0000;
    run_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 0, 16'h0);
    digits = 16'h0105;
    run_frame(8'h92, 8'hC0, 8'hF9, 8'hFF, 0, 16'h0);

    // Frame coherence: change lands while digit 2 is driven.
    lz_blank = 1'b0;
    digits   = 16'h0009;
    run_frame(8'h90, 8'hC0, 8'hC0, 8'hC0, 14, 16'h0010);
    run_frame(8'hC0, 8'hF9, 8'hC0, 8'hC0, 0, 16'h0);

    // Reset while digit 2 is driven.
    digits = 16'h1234;
    repeat (14) @(negedge clk);
    chk("pre_rst sel", {4'h0, sel}, 8'h0B);
    chk("pre_rst seg", seg, 8'hA4);
    digits = 16'h5678;
    res = 1'b0;
    #1;
    chk("mid_rst seg", seg, 8'hFF);
    chk("mid_rst sel", {4'h0, sel}, 8'h0F);
    chk("mid_rst frame", {7'd0, frame}, 8'd0);
    @(negedge clk);
    chk("mid_rst hold sel", {4'h0, sel}, 8'h0F);
    res      = 1'b1;
    c        = 0;
    prev_sel = 4'hF;
    run_frame(8'h80, 8'hF8, 8'h82, 8'h92, 0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
